// File: rtl/mux_pipe_n_if.sv
// Operand-select pipeline stage bus: upstream select/handshake, flush, and
// downstream registered data with valid/ready.
interface mux_pipe_n_if #(
    parameter int unsigned DATA_LENGTH = 8,
    parameter int unsigned NUM_INPUTS  = 4,
    parameter int unsigned SEL_WIDTH   = 2
);
    logic [NUM_INPUTS*DATA_LENGTH-1:0] in_bus;
    logic [SEL_WIDTH-1:0]              sel;
    logic                              in_valid;
    logic                              in_ready;
    logic                              flush;
    logic [DATA_LENGTH-1:0]            out;
    logic                              out_err;
    logic                              out_valid;
    logic                              out_ready;

    modport master (
        output in_bus, sel, in_valid, flush, out_ready,
        input  in_ready, out, out_err, out_valid
    );

    modport slave (
        input  in_bus, sel, in_valid, flush, out_ready,
        output in_ready, out, out_err, out_valid
    );
endinterface

// File: rtl/mux_pipe_n.sv
// N-input binary-select mux feeding a 2-entry skid buffer with valid/ready
// handshake and synchronous flush; all outputs come straight from flops.
module mux_pipe_n #(
    parameter int unsigned DATA_LENGTH = 8,
    parameter int unsigned NUM_INPUTS  = 4,
    parameter int unsigned SEL_WIDTH   = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    mux_pipe_n_if.slave   bus
);

    typedef struct packed {
        logic                   err;
        logic [DATA_LENGTH-1:0] data;
    } entry_t;

    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_ONE   = 2'b01;
    localparam logic [1:0] ST_TWO   = 2'b11;

    entry_t main_q, skid_q;
    entry_t sel_entry;
    logic   main_valid_q, main_valid_d;
    logic   skid_valid_q, skid_valid_d;
    logic   in_ready_q;
    logic   accept, pop;
    logic   main_load, main_from_skid, skid_load;
    logic [1:0] state;

    assign state  = {skid_valid_q, main_valid_q};
    assign accept = bus.in_valid && in_ready_q;
    assign pop    = main_valid_q && bus.out_ready;

    // Selects without a matching input produce a zero entry flagged as error
    always_comb begin
        sel_entry      = '0;
        sel_entry.err  = 1'b1;
        for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
            if (bus.sel == SEL_WIDTH'(i)) begin
                sel_entry.data = bus.in_bus[i*DATA_LENGTH +: DATA_LENGTH];
                sel_entry.err  = 1'b0;
            end
        end
    end

    // Next occupancy
    always_comb begin
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        if (bus.flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else begin
            case (state)
                ST_EMPTY: if (accept) main_valid_d = 1'b1;
                ST_ONE: begin
                    if (accept && !pop)      skid_valid_d = 1'b1;
                    else if (pop && !accept) main_valid_d = 1'b0;
                end
                ST_TWO:   if (pop) skid_valid_d = 1'b0;
                default: ;
            endcase
        end
    end

    // Entry load controls
    always_comb begin
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        if (!bus.flush) begin
            case (state)
                ST_EMPTY: main_load = accept;
                ST_ONE: begin
                    main_load = accept && pop;
                    skid_load = accept && !pop;
                end
                ST_TWO: begin
                    main_load      = pop;
                    main_from_skid = pop;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
            main_q       <= '0;
            skid_q       <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= !skid_valid_d;
            if (main_load) main_q <= main_from_skid ? skid_q : sel_entry;
            if (skid_load) skid_q <= sel_entry;
        end
    end

    assign bus.out       = main_q.data;
    assign bus.out_err   = main_q.err;
    assign bus.out_valid = main_valid_q;
    assign bus.in_ready  = in_ready_q;

endmodule

// File: tb/tb_mux_pipe_n.sv
// Directed bench for mux_pipe_n: select, out-of-range error, skid back-pressure,
// accept+pop, flush and asynchronous reset, with hand-computed expectations.
module tb_mux_pipe_n;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    mux_pipe_n_if #(.DATA_LENGTH(8), .NUM_INPUTS(4), .SEL_WIDTH(2)) ifa ();
    mux_pipe_n_if #(.DATA_LENGTH(8), .NUM_INPUTS(3), .SEL_WIDTH(2)) ifb ();

    mux_pipe_n #(.DATA_LENGTH(8), .NUM_INPUTS(4), .SEL_WIDTH(2)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa)
    );

    mux_pipe_n #(.DATA_LENGTH(8), .NUM_INPUTS(3), .SEL_WIDTH(2)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks head of DUT A: valid, data, in_ready
    task automatic check_a(input string tag, input logic v, input logic [7:0] d, input logic rdy);
        check({tag, ".valid"}, 32'(ifa.out_valid), 32'(v));
        if (v) check({tag, ".out"}, 32'(ifa.out), 32'(d));
        check({tag, ".in_ready"}, 32'(ifa.in_ready), 32'(rdy));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        ifa.in_bus = {8'h44, 8'h33, 8'h22, 8'h11};
        ifa.sel = 2'd0; ifa.in_valid = 1'b1; ifa.flush = 1'b0; ifa.out_ready = 1'b1;
        ifb.in_bus = {8'h33, 8'h22, 8'h11};
        ifb.sel = 2'd0; ifb.in_valid = 1'b0; ifb.flush = 1'b0; ifb.out_ready = 1'b1;

        // Reset holds state despite in_valid = 1
        #22;
        check("rst.valid", 32'(ifa.out_valid), 32'd0);
        check("rst.in_ready", 32'(ifa.in_ready), 32'd1);
        check("rst.out", 32'(ifa.out), 32'd0);
        check("rst.err", 32'(ifa.out_err), 32'd0);
        rst_n = 1'b1;

        // Select sweep, one item per cycle
        ifa.sel = 2'd0; tick(); check_a("sel0", 1'b1, 8'h11, 1'b1);
        check("sel0.err", 32'(ifa.out_err), 32'd0);
        ifa.sel = 2'd1; tick(); check_a("sel1", 1'b1, 8'h22, 1'b1);
        ifa.sel = 2'd2; tick(); check_a("sel2", 1'b1, 8'h33, 1'b1);
        ifa.sel = 2'd3; tick(); check_a("sel3", 1'b1, 8'h44, 1'b1);
        ifa.in_valid = 1'b0; tick(); check_a("drain0", 1'b0, 8'h00, 1'b1);

        // Out-of-range select on 3-input instance
        ifb.in_valid = 1'b1; ifb.sel = 2'd3; tick();
        check("oor.valid", 32'(ifb.out_valid), 32'd1);
        check("oor.out", 32'(ifb.out), 32'd0);
        check("oor.err", 32'(ifb.out_err), 32'd1);
        ifb.sel = 2'd2; tick();
        check("inr.out", 32'(ifb.out), 32'h33);
        check("inr.err", 32'(ifb.out_err), 32'd0);
        ifb.in_valid = 1'b0; tick();
        check("oor.drain", 32'(ifb.out_valid), 32'd0);

        // Back-pressure: A to main, B to skid, C held upstream
        ifa.out_ready = 1'b0; ifa.in_valid = 1'b1;
        ifa.sel = 2'd0; tick(); check_a("bp.A", 1'b1, 8'h11, 1'b1);
        ifa.sel = 2'd1; tick(); check_a("bp.B", 1'b1, 8'h11, 1'b0);
        ifa.sel = 2'd2; tick(); check_a("bp.hold", 1'b1, 8'h11, 1'b0);
        ifa.out_ready = 1'b1;
        tick(); check_a("bp.outB", 1'b1, 8'h22, 1'b1);
        // ONE with accept and pop together: head replaced by C
        tick(); check_a("bp.outC", 1'b1, 8'h33, 1'b1);
        ifa.in_valid = 1'b0;
        tick(); check_a("bp.empty", 1'b0, 8'h00, 1'b1);

        // Flush from TWO with D offered
        ifa.out_ready = 1'b0; ifa.in_valid = 1'b1;
        ifa.sel = 2'd0; tick();
        ifa.sel = 2'd1; tick(); check_a("fl.two", 1'b1, 8'h11, 1'b0);
        ifa.flush = 1'b1; ifa.sel = 2'd3; tick(); check_a("fl.two.after", 1'b0, 8'h00, 1'b1);
        ifa.flush = 1'b0; ifa.in_valid = 1'b0; tick(); check_a("fl.noD", 1'b0, 8'h00, 1'b1);

        // Flush from ONE while in_ready = 1: offered item still dropped
        ifa.in_valid = 1'b1; ifa.sel = 2'd2; tick(); check_a("fl.one", 1'b1, 8'h33, 1'b1);
        ifa.flush = 1'b1; ifa.sel = 2'd3; tick(); check_a("fl.one.after", 1'b0, 8'h00, 1'b1);
        ifa.flush = 1'b0; ifa.out_ready = 1'b1; ifa.sel = 2'd1; tick();
        check_a("fl.resume", 1'b1, 8'h22, 1'b1);
        ifa.in_valid = 1'b0; tick(); check_a("fl.resume.drain", 1'b0, 8'h00, 1'b1);

        // Asynchronous reset while in TWO
        ifa.out_ready = 1'b0; ifa.in_valid = 1'b1;
        ifa.sel = 2'd2; tick();
        ifa.sel = 2'd3; tick(); check_a("ar.two", 1'b1, 8'h33, 1'b0);
        ifa.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("ar.valid", 32'(ifa.out_valid), 32'd0);
        check("ar.in_ready", 32'(ifa.in_ready), 32'd1);
        check("ar.out", 32'(ifa.out), 32'd0);
        #1 rst_n = 1'b1;
        ifa.out_ready = 1'b1; ifa.in_valid = 1'b1; ifa.sel = 2'd1; tick();
        check_a("ar.first", 1'b1, 8'h22, 1'b1);
        ifa.in_valid = 1'b0; tick(); check_a("ar.drain", 1'b0, 8'h00, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux_pipe_n.md
# mux_pipe_n

Parametrised N-input operand select with a registered, flow-controlled output stage for the pipeline datapath. It picks one of NUM_INPUTS buses with a binary select and captures the result into a 2-entry skid buffer with a valid/ready handshake on both sides. The stage accepts one item per cycle and tolerates downstream back-pressure without combinational ready paths. Synchronous flush support allows use at a pipeline register boundary (e.g. ID/EX operand forwarding).

## Interface
- DATA_LENGTH, 8, width of each input bus and of the output
- NUM_INPUTS, 4, number of selectable inputs, legal range 2..16
- SEL_WIDTH, 2, select width; must equal ceil(log2(NUM_INPUTS))

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_bus  input  NUM_INPUTS*DATA_LENGTH  flattened inputs; input i at [i*DATA_LENGTH +: DATA_LENGTH]
- sel  input  SEL_WIDTH  binary select, sampled with in_valid
- in_valid  input  1  upstream item present
- in_ready  output  1  stage can accept this cycle
- flush  input  1  synchronous discard of all held and incoming items
- out  output  DATA_LENGTH  head item data
- out_err  output  1  head item was produced by an out-of-range select
- out_valid  output  1  head item present
- out_ready  input  1  downstream accepts head this cycle

## Operation
- Accept is `in_valid && in_ready` at a rising edge. Pop is `out_valid && out_ready` at a rising edge.
- Selected value:
  - sel < NUM_INPUTS: in_bus slice sel, err = 0.
  - sel >= NUM_INPUTS: all zeros, err = 1.
  - data and err are stored together as one entry.
- Storage is two entries, main (drives out/out_err/out_valid) and skid, each with a valid bit.
- State is derived from the valid bits: EMPTY (none), ONE (main only), TWO (main and skid).
- Transitions, with flush = 0:
  - EMPTY + accept -> ONE; the entry goes to main.
  - ONE + accept + pop -> ONE; main is replaced by the new entry.
  - ONE + accept, no pop -> TWO; the new entry goes to skid.
  - ONE + pop, no accept -> EMPTY.
  - TWO + pop -> ONE; skid moves to main. No accept is possible in TWO.
  - Any other combination: hold.
- in_ready = !skid_valid, taken directly from a flop with no combinational path from out_ready.
- flush = 1:
  - Both valid bits clear at the next edge.
  - An item offered in the same cycle is dropped, even if in_ready = 1.
  - A pop in the same cycle still completes downstream.
  - Flush has priority over every transition.
- Ordering is strict FIFO. No item is lost or duplicated without a flush.
- While out_valid = 1 and out_ready = 0, out and out_err hold stable.
- Entry data registers update only on load. No enable is needed on invalid entries, but their contents are don't-care.
- Reset (rst_n = 0, asynchronous):
  - main_valid, skid_valid, out, out_err all 0.
  - out_valid = 0, in_ready = 1.
  - Inputs are ignored while in reset.
- Reset mid-operation discards all entries immediately, without waiting for a clock edge.

## Timing
- Latency: accept at edge k gives out_valid = 1 after edge k when the stage is EMPTY or popping in that cycle.
- Throughput: 1 item/cycle sustained while out_ready = 1.
- in_ready falls the cycle after entering TWO and rises the cycle after leaving it. Upstream must not assume a combinational ready.
- Flush takes effect at the first edge where flush = 1. out_valid = 0 and in_ready = 1 from the following cycle.
- out, out_err and out_valid are all flop outputs.

## Test plan
- Reset and select:
  - Stimulus: hold rst_n = 0, then release. NUM_INPUTS = 4, DATA_LENGTH = 8, in_bus = {8'h44, 8'h33, 8'h22, 8'h11}. Offer sel = 0..3 on consecutive cycles with out_ready = 1.
  - Required: during reset, out_valid = 0, in_ready = 1, out = 0. After reset, out = 11, 22, 33, 44 on consecutive cycles, each one cycle after its accept.
- Out-of-range select:
  - Stimulus: NUM_INPUTS = 3, SEL_WIDTH = 2, sel = 3, in_valid = 1.
  - Required: an entry appears with out = 0 and out_err = 1. The next entry, with sel = 2, has out_err = 0.
- Back-pressure and skid:
  - Stimulus: out_ready = 0, stream A, B, C with in_valid held high.
  - Required: A in main, B in skid, in_ready = 0 from the cycle after B is accepted, C held upstream.
  - Then out_ready = 1: A, B, C delivered in order with no gap after A.
- Simultaneous accept and pop in ONE:
  - Stimulus: the stage is in ONE and a new item is accepted in the same cycle as a pop.
  - Required: the state stays ONE and out switches to the new item at the next edge.
- Flush:
  - Stimulus: the stage is in TWO, then flush = 1 with in_valid = 1 (item D offered).
  - Required: the next cycle has out_valid = 0 and in_ready = 1. D is never output. Normal traffic resumes after flush deasserts.
- Asynchronous reset mid-stream:
  - Stimulus: pulse rst_n low between clock edges while the stage is in TWO.
  - Required: out_valid = 0 immediately, with no edge needed. After release, the first accepted item is the first one output.
